// File: rtl/cpuid_query_unit_if.sv
// rtl/cpuid_query_unit_if.sv - request/response bundle for the CPUID query unit
// The master drives queries and consumes responses; the slave is the unit itself.
interface cpuid_query_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_leaf;
   logic [31:0] req_subleaf;
   logic [31:0] feat_disable;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_data0;
   logic [63:0] rsp_data1;
   logic [63:0] rsp_data2;
   logic [63:0] rsp_data3;
   logic        rsp_unknown;
   logic [31:0] query_count;

   modport master (
      output req_valid, req_leaf, req_subleaf, feat_disable, rsp_ready,
      input  req_ready, rsp_valid, rsp_data0, rsp_data1, rsp_data2, rsp_data3,
             rsp_unknown, query_count
   );

   modport slave (
      input  req_valid, req_leaf, req_subleaf, feat_disable, rsp_ready,
      output req_ready, rsp_valid, rsp_data0, rsp_data1, rsp_data2, rsp_data3,
             rsp_unknown, query_count
   );
endinterface

// File: rtl/cpuid_query_unit.sv
// rtl/cpuid_query_unit.sv - sequential CPUID leaf/subleaf responder with programmable latency
// One query in flight; response words derive only from values captured at accept.
module cpuid_query_unit #(
   parameter int unsigned CORE_COUNT        = 1,
   parameter int unsigned THREADS_PER_CORE  = 1,
   parameter int unsigned VECTOR_BITS       = 128,
   parameter int unsigned ARCH_BITS         = 64,
   parameter logic [7:0]  FPU_TIER          = 8'h01,  // CARBON_AMD_FPU_TIER_P0_AM9511
   parameter int unsigned RESP_LATENCY      = 1,
   parameter int unsigned DISCOVERY_VERSION = 2
) (
   input  logic               clk,
   input  logic               rst,
   cpuid_query_unit_if.slave  bus
);
   localparam logic [31:0] LEAF_VENDOR    = 32'h0000_0000;
   localparam logic [31:0] LEAF_ID        = 32'h0000_0001;
   localparam logic [31:0] LEAF_TIERS     = 32'h0000_0002;
   localparam logic [31:0] LEAF_FEATURES0 = 32'h0000_0003;
   localparam logic [31:0] LEAF_TOPOLOGY  = 32'h0000_0004;
   localparam logic [31:0] LEAF_ERRATA0   = 32'h0000_0005;

   localparam logic [7:0]  TIER_LADDER_Z80     = 8'h01;
   localparam logic [7:0]  TIER_LADDER_AMD_FPU = 8'h02;
   localparam logic [7:0]  TIER_P7_Z480        = 8'h07;

   // FEATURES0 bits: CSR_NAMESPACE, FABRIC, CPUID, IOMMU_HOOKS, Z480_NATIVE_64
   localparam logic [31:0] FEATURES0_ALL = 32'h0000_001F;
   localparam logic [31:0] CHIP_FLAGS    = 32'h0000_001F;

   localparam logic [31:0] CORES32   = 32'(CORE_COUNT);
   localparam logic [31:0] THREADS32 = 32'(THREADS_PER_CORE);
   localparam logic [15:0] VEC16     = 16'(VECTOR_BITS);
   localparam logic [15:0] ARCH16    = 16'(ARCH_BITS);
   localparam logic [15:0] DISC16    = 16'(DISCOVERY_VERSION);
   localparam logic [2:0]  CNT_INIT  = 3'(RESP_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [31:0]       leaf_q, leaf_d;
   logic [31:0]       sub_q, sub_d;
   logic [31:0]       fd_q, fd_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [3:0][31:0]  words_q, words_d;
   logic              unknown_q, unknown_d;
   logic [31:0]       query_count_q, query_count_d;

   logic [3:0][31:0]  w;
   logic              unk;
   logic [31:0]       core_id;

   always_comb begin
      w       = '0;
      unk     = 1'b0;
      core_id = sub_q - 32'd1;
      case (leaf_q)
         LEAF_VENDOR: begin
            w[0] = {DISC16, LEAF_ERRATA0[15:0]};
            w[1] = 32'h4252_4143;
            w[2] = 32'h5A2D_4E4F;
            w[3] = 32'h2030_3834;
         end
         LEAF_ID: begin
            w[0] = 32'h0107_9000;
            w[1] = CHIP_FLAGS;
         end
         LEAF_TIERS: begin
            w[0] = {8'h00, TIER_P7_Z480, TIER_P7_Z480, TIER_LADDER_Z80};
            w[1] = {8'h00, FPU_TIER, FPU_TIER, TIER_LADDER_AMD_FPU};
         end
         LEAF_FEATURES0: w[0] = FEATURES0_ALL & ~fd_q;
         LEAF_TOPOLOGY: begin
            // Subleaves past the last core read as zero but the leaf itself exists.
            if (sub_q == 32'd0) begin
               w[0] = {THREADS32[15:0], CORES32[15:0]};
               w[1] = {ARCH16, VEC16};
               w[2] = CORES32;
            end else if (sub_q <= CORES32) begin
               w[0] = core_id;
               w[1] = core_id * THREADS32;
               w[2] = THREADS32;
            end
         end
         default: unk = 1'b1;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      leaf_d        = leaf_q;
      sub_d         = sub_q;
      fd_d          = fd_q;
      rsp_valid_d   = rsp_valid_q;
      words_d       = words_q;
      unknown_d     = unknown_q;
      query_count_d = query_count_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               leaf_d  = bus.req_leaf;
               sub_d   = bus.req_subleaf;
               fd_d    = bus.feat_disable;
               cnt_d   = CNT_INIT;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == 3'd0) begin
               words_d     = w;
               unknown_d   = unk;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               if (query_count_q != 32'hFFFF_FFFF) begin
                  query_count_d = query_count_q + 32'd1;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      req_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         leaf_q        <= '0;
         sub_q         <= '0;
         fd_q          <= '0;
         req_ready_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         words_q       <= '0;
         unknown_q     <= 1'b0;
         query_count_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         leaf_q        <= leaf_d;
         sub_q         <= sub_d;
         fd_q          <= fd_d;
         req_ready_q   <= req_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         words_q       <= words_d;
         unknown_q     <= unknown_d;
         query_count_q <= query_count_d;
      end
   end

   assign bus.req_ready   = req_ready_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_data0   = {32'h0, words_q[0]};
   assign bus.rsp_data1   = {32'h0, words_q[1]};
   assign bus.rsp_data2   = {32'h0, words_q[2]};
   assign bus.rsp_data3   = {32'h0, words_q[3]};
   assign bus.rsp_unknown = unknown_q;
   assign bus.query_count = query_count_q;
endmodule

// File: tb/tb_cpuid_query_unit.sv
// tb/tb_cpuid_query_unit.sv - scoreboard bench for cpuid_query_unit
// dut_a: 4 cores x 2 threads, latency 4; dut_b: defaults, latency 1.
module tb_cpuid_query_unit;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   cpuid_query_unit_if bus_a ();
   cpuid_query_unit_if bus_b ();

   cpuid_query_unit #(.CORE_COUNT(4), .THREADS_PER_CORE(2), .RESP_LATENCY(4)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a));
   cpuid_query_unit #(.RESP_LATENCY(1)) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b));

   logic        req_valid [2];
   logic [31:0] req_leaf  [2];
   logic [31:0] req_sub   [2];
   logic [31:0] feat_dis  [2];
   logic        rsp_ready [2];
   logic        req_ready_w [2];
   logic        rsp_valid_w [2];
   logic        unknown_w   [2];
   logic [31:0] count_w     [2];
   logic [63:0] data_w      [2][4];

   assign bus_a.req_valid = req_valid[0];  assign bus_b.req_valid = req_valid[1];
   assign bus_a.req_leaf = req_leaf[0];    assign bus_b.req_leaf = req_leaf[1];
   assign bus_a.req_subleaf = req_sub[0];  assign bus_b.req_subleaf = req_sub[1];
   assign bus_a.feat_disable = feat_dis[0]; assign bus_b.feat_disable = feat_dis[1];
   assign bus_a.rsp_ready = rsp_ready[0];  assign bus_b.rsp_ready = rsp_ready[1];
   assign req_ready_w[0] = bus_a.req_ready; assign req_ready_w[1] = bus_b.req_ready;
   assign rsp_valid_w[0] = bus_a.rsp_valid; assign rsp_valid_w[1] = bus_b.rsp_valid;
   assign unknown_w[0] = bus_a.rsp_unknown; assign unknown_w[1] = bus_b.rsp_unknown;
   assign count_w[0] = bus_a.query_count;  assign count_w[1] = bus_b.query_count;
   assign data_w[0][0] = bus_a.rsp_data0;  assign data_w[1][0] = bus_b.rsp_data0;
   assign data_w[0][1] = bus_a.rsp_data1;  assign data_w[1][1] = bus_b.rsp_data1;
   assign data_w[0][2] = bus_a.rsp_data2;  assign data_w[1][2] = bus_b.rsp_data2;
   assign data_w[0][3] = bus_a.rsp_data3;  assign data_w[1][3] = bus_b.rsp_data3;

   int unsigned lat [2] = '{4, 1};

   typedef struct {
      logic [3:0][31:0] w;
      logic             unk;
      int               dut;
      int unsigned      acc;
   } exp_t;

   exp_t sb[$];
   exp_t cur [2];
   logic seen [2] = '{1'b0, 1'b0};

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Monitor: pop on the first cycle of each response, then re-check every held cycle.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            seen[d] = 1'b0;
         end else if (rsp_valid_w[d]) begin
            if (!seen[d]) begin
               if (sb.size() == 0 || sb[0].dut != d) begin
                  check($sformatf("unexpected_rsp_dut%0d", d), 64'(rsp_valid_w[d]), 64'd0);
               end else begin
                  cur[d]  = sb.pop_front();
                  seen[d] = 1'b1;
                  check($sformatf("latency_dut%0d", d), 64'(cyc), 64'(cur[d].acc + lat[d]));
               end
            end
            if (seen[d]) begin
               for (int k = 0; k < 4; k++)
                  check($sformatf("data%0d_dut%0d", k, d), data_w[d][k], {32'h0, cur[d].w[k]});
               check($sformatf("unknown_dut%0d", d), 64'(unknown_w[d]), 64'(cur[d].unk));
               if (rsp_ready[d]) seen[d] = 1'b0;
            end
         end
      end
   end

   task automatic issue(input int d, input logic [31:0] leaf, input logic [31:0] sub,
                        input logic [31:0] fd, input logic [3:0][31:0] w, input logic unk);
      exp_t e;
      int   t;
      @(negedge clk);
      req_valid[d] = 1'b1;
      req_leaf[d]  = leaf;
      req_sub[d]   = sub;
      feat_dis[d]  = fd;
      t = 0;
      while (!req_ready_w[d] && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         fail_now("accept_timeout");
      end else begin
         e.w = w; e.unk = unk; e.dut = d; e.acc = cyc + 1;
         sb.push_back(e);
      end
      @(posedge clk);
      #1 req_valid[d] = 1'b0;
   endtask

   task automatic wait_idle(input int d);
      int t;
      t = 0;
      @(negedge clk);
      while ((sb.size() != 0 || rsp_valid_w[d]) && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) fail_now("response_timeout");
   endtask

   task automatic wait_rsp(input int d);
      int t;
      t = 0;
      while (!rsp_valid_w[d] && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) fail_now("rsp_valid_timeout");
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      check("rst_rsp_valid", 64'(rsp_valid_w[0]), 64'd0);
      check("rst_req_ready", 64'(req_ready_w[0]), 64'd0);
      check("rst_count", 64'(count_w[0]), 64'd0);
      @(negedge clk);
      check("post_rst_req_ready", 64'(req_ready_w[0]), 64'd1);
   endtask

   localparam logic [3:0][31:0] W_VENDOR = {32'h2030_3834, 32'h5A2D_4E4F, 32'h4252_4143, 32'h0002_0005};
   localparam logic [3:0][31:0] W_ID     = {32'h0, 32'h0, 32'h0000_001F, 32'h0107_9000};
   localparam logic [3:0][31:0] W_TIERS  = {32'h0, 32'h0, 32'h0001_0102, 32'h0007_0701};
   localparam logic [3:0][31:0] W_ZERO   = '0;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0; req_leaf[d] = '0; req_sub[d] = '0;
         feat_dis[d] = '0; rsp_ready[d] = 1'b1;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_req_ready", 64'(req_ready_w[0]), 64'd0);
      check("reset_rsp_valid", 64'(rsp_valid_w[0]), 64'd0);
      check("reset_data0", data_w[0][0], 64'd0);
      check("reset_unknown", 64'(unknown_w[0]), 64'd0);
      check("reset_count", 64'(count_w[0]), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", 64'(req_ready_w[1]), 64'd1);

      // Latency 1 on dut_b: VENDOR, ID, TIERS
      issue(1, 32'h0, 32'h0, 32'h0, W_VENDOR, 1'b0);
      wait_idle(1);
      check("count_b_after_vendor", 64'(count_w[1]), 64'd1);
      issue(1, 32'h1, 32'h0, 32'h0, W_ID, 1'b0);
      wait_idle(1);
      issue(1, 32'h2, 32'h0, 32'h0, W_TIERS, 1'b0);
      wait_idle(1);

      // Latency 4 on dut_a: FEATURES0 with CPUID disabled; live inputs changed while BUSY
      issue(0, 32'h3, 32'h0, 32'h0000_0004, {32'h0, 32'h0, 32'h0, 32'h0000_001B}, 1'b0);
      feat_dis[0] = 32'hFFFF_FFFF;
      req_leaf[0] = 32'hDEAD_0000;
      wait_idle(0);
      feat_dis[0] = '0;
      check("count_a_after_feat", 64'(count_w[0]), 64'd1);

      // Topology enumeration, including the last core and one past it
      issue(0, 32'h4, 32'd0, 32'h0, {32'h0, 32'd4, 32'h0040_0080, 32'h0002_0004}, 1'b0);
      wait_idle(0);
      issue(0, 32'h4, 32'd3, 32'h0, {32'h0, 32'd2, 32'd4, 32'd2}, 1'b0);
      wait_idle(0);
      issue(0, 32'h4, 32'd4, 32'h0, {32'h0, 32'd2, 32'd6, 32'd3}, 1'b0);
      wait_idle(0);
      issue(0, 32'h4, 32'd5, 32'h0, W_ZERO, 1'b0);
      wait_idle(0);
      issue(0, 32'hDEAD_0000, 32'h0, 32'h0, W_ZERO, 1'b1);
      wait_idle(0);
      issue(0, 32'h0, 32'd7, 32'hFFFF_FFFF, W_VENDOR, 1'b0);
      wait_idle(0);
      check("count_a_after_seq", 64'(count_w[0]), 64'd7);

      // Backpressure: response held while requests are pulsed
      rsp_ready[0] = 1'b0;
      issue(0, 32'h2, 32'h0, 32'h0, W_TIERS, 1'b0);
      wait_rsp(0);
      for (int i = 0; i < 10; i++) begin
         req_valid[0] = i[0];
         req_leaf[0]  = 32'h1;
         @(negedge clk);
         check("bp_req_ready", 64'(req_ready_w[0]), 64'd0);
         check("bp_count", 64'(count_w[0]), 64'd7);
      end
      req_valid[0] = 1'b0;
      rsp_ready[0] = 1'b1;
      wait_idle(0);
      check("count_a_after_bp", 64'(count_w[0]), 64'd8);
      repeat (6) @(negedge clk);

      // Reset while BUSY, then while RESP; the dropped queries must never appear
      issue(0, 32'h3, 32'h0, 32'h0, W_ZERO, 1'b0);
      pulse_reset();
      repeat (8) @(negedge clk);
      rsp_ready[0] = 1'b0;
      issue(0, 32'h1, 32'h0, 32'h0, W_ID, 1'b0);
      wait_rsp(0);
      pulse_reset();
      rsp_ready[0] = 1'b1;
      repeat (8) @(negedge clk);
      check("count_a_after_resets", 64'(count_w[0]), 64'd0);

      // Saturation on dut_b
      @(negedge clk);
      force dut_b.query_count_q = 32'hFFFF_FFFF;
      #1 release dut_b.query_count_q;
      check("count_b_preset", 64'(count_w[1]), 64'hFFFF_FFFF);
      issue(1, 32'h0, 32'h0, 32'h0, W_VENDOR, 1'b0);
      wait_idle(1);
      check("count_b_saturated", 64'(count_w[1]), 64'hFFFF_FFFF);

      repeat (4) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/cpuid_query_unit.md
Name: cpuid_query_unit

Overview:
- Sequential, parametrised CPUID responder for Z480-class cores.
- Sits behind the CSR-window CPUID transport. Accepts one leaf/subleaf query at a time over a valid/ready request channel and returns four 64-bit data lanes over a valid/ready response channel after a programmable latency.
- Adds three things over the v1 combinational leaf model:
  - subleaf enumeration of per-core topology entries;
  - a runtime feature-disable mask;
  - an unknown-leaf flag and a saturating query counter.

Parameters:
- CORE_COUNT, 1, number of cores reported; legal 1..65535.
- THREADS_PER_CORE, 1, threads per core; legal 1..65535.
- VECTOR_BITS, 128, vector width reported in TOPOLOGY.
- ARCH_BITS, 64, architectural width reported in TOPOLOGY.
- FPU_TIER, CARBON_AMD_FPU_TIER_P0_AM9511, FPU tier reported in TIERS word1.
- RESP_LATENCY, 1, cycles from request accept to rsp_valid; legal 1..8.
- DISCOVERY_VERSION, 2, discovery_format_version in VENDOR word0[31:16].

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  query present.
- req_ready  out  1  unit can accept a query.
- req_leaf  in  32  leaf index.
- req_subleaf  in  32  subleaf index.
- feat_disable  in  32  bits to clear from FEATURES0 word0; sampled at request accept.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data0..rsp_data3  out  64 each  words w0..w3, zero-extended to 64 bits.
- rsp_unknown  out  1  leaf not implemented; data lanes all zero.
- query_count  out  32  saturating count of completed responses.

Behaviour:
- Reset and clocking:
  - Single clock domain. rst is synchronous and active-high.
  - Reset values: req_ready=0 during the rst cycle, then 1; rsp_valid=0; rsp_data*=0; rsp_unknown=0; query_count=0; FSM=IDLE; latency counter=0.
- FSM IDLE:
  - req_ready=1.
  - When req_valid: capture leaf, subleaf and feat_disable; load counter with RESP_LATENCY-1; go to BUSY.
- FSM BUSY:
  - req_ready=0.
  - Response words are computed from the captured values only; the live inputs are ignored.
  - When counter==0: register the response and go to RESP, so rsp_valid rises exactly RESP_LATENCY cycles after the accept edge. Otherwise decrement the counter.
- FSM RESP:
  - rsp_valid=1. Data and unknown flag are stable until the handshake.
  - When rsp_ready: increment query_count (saturating at 0xFFFF_FFFF) and go to IDLE.
  - No back-to-back overlap: the next request is accepted no earlier than the cycle after the response handshake.
- Leaf map (upper 32 bits of every data lane are 0):
  - VENDOR:
    - w0[15:0]=CARBON_CPUID_LEAF_ERRATA0[15:0]; w0[31:16]=DISCOVERY_VERSION.
    - w1=0x42524143, w2=0x5A2D4E4F, w3=0x20303834 (the string "CARBON-Z480 ").
  - ID:
    - w0=0x01079000.
    - w1=chip flags: bits 0..4 set (U, S, H, OOO, MMU scaffold); all others 0.
  - TIERS:
    - w0 = {8'h00, P7_Z480, P7_Z480, CARBON_TIER_LADDER_Z80}.
    - w1 = {8'h00, FPU_TIER, FPU_TIER, CARBON_TIER_LADDER_AMD_FPU}.
  - FEATURES0:
    - w0 = (CSR_NAMESPACE | FABRIC | CPUID | IOMMU_HOOKS | Z480_NATIVE_64) & ~feat_disable_captured.
  - TOPOLOGY, subleaf 0:
    - w0 = {THREADS_PER_CORE[15:0], CORE_COUNT[15:0]}.
    - w1 = {ARCH_BITS[15:0], VECTOR_BITS[15:0]}.
    - w2 = CORE_COUNT (count of enumerable subleaves).
  - TOPOLOGY, subleaf n with 1<=n<=CORE_COUNT:
    - w0 = n-1 (core_id).
    - w1 = (n-1)*THREADS_PER_CORE (first thread id), computed in 32 bits, truncated.
    - w2 = THREADS_PER_CORE.
  - TOPOLOGY, subleaf n > CORE_COUNT: all words 0; rsp_unknown=0, because the leaf exists.
  - Any other leaf: all words 0; rsp_unknown=1.
  - Subleaf is ignored for all leaves except TOPOLOGY.
- Boundary conditions:
  - req_valid held while BUSY or RESP: not accepted; the requester must hold it.
  - rsp_ready asserted while not in RESP: ignored.
  - rst asserted in any state: next cycle is IDLE with all outputs at reset values; an in-flight query is dropped and not counted.
  - query_count at 0xFFFF_FFFF: holds.

Test Plan:
- Reset then request VENDOR, RESP_LATENCY=1, rsp_ready=1 -> rsp_valid exactly 1 cycle after accept; data1=0x42524143, data0[31:16]=2; query_count=1.
- RESP_LATENCY=4, request FEATURES0 with feat_disable = CPUID_MASK -> rsp_valid on the 4th cycle; w0 has the CPUID bit cleared and the other four bits set. Changing feat_disable during BUSY has no effect.
- CORE_COUNT=4, THREADS_PER_CORE=2, TOPOLOGY subleafs 0, 3, 5:
  - subleaf 0 -> w0=0x00020004, w2=4;
  - subleaf 3 -> w0=2, w1=4, w2=2;
  - subleaf 5 -> all words zero, rsp_unknown=0.
- Request leaf 0xDEAD_0000 -> all data lanes 0, rsp_unknown=1.
- Backpressure: hold rsp_ready=0 for 10 cycles while pulsing req_valid -> data stable, req_ready=0, no second accept, query_count unchanged until the handshake.
- Assert rst during BUSY and during RESP -> next cycle rsp_valid=0, req_ready=1, query_count=0, no response emitted; force count to 0xFFFF_FFFF and complete one query -> count stays 0xFFFF_FFFF.
